// File: rtl/ahbl_cache_bridge_pkg.sv
// ahbl_cache_bridge_pkg
//   Shared definitions for the AHB-Lite to cache bridge: controller state
//   encoding and the AHB HTRANS/HSIZE codes the bridge decodes.
package ahbl_cache_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    WR_WAIT_HI,
    WR_WAIT_LO,
    ERR1,
    ERR2
  } state_t;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

endpackage

// File: rtl/ahbl_strb_gen.sv
// ahbl_strb_gen
//   Combinational byte-lane mask and alignment check for one AHB transfer.
//   Ports:
//     hsize      in  3  transfer size (0 byte, 1 half, 2 word)
//     addr       in  2  low byte-address bits
//     mask       out 4  byte enables for the addressed lanes
//     misaligned out 1  transfer not naturally aligned, or size unsupported
module ahbl_strb_gen
  import ahbl_cache_bridge_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr,
  output logic [3:0] mask,
  output logic       misaligned
);

  always_comb begin
    mask       = '0;
    misaligned = 1'b0;
    case (hsize)
      HSIZE_BYTE: mask = 4'b0001 << addr;
      HSIZE_HALF: begin
        mask       = 4'b0011 << addr;
        misaligned = addr[0];
      end
      HSIZE_WORD: begin
        mask       = '1;
        misaligned = (addr != 2'b00);
      end
      default:    misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahbl_cache_bridge.sv
// ahbl_cache_bridge
//   AHB-Lite slave turning each bus transfer into one request on the
//   write-back cache's single-word request/busy interface.
//   Ports:
//     clk, rst_x          clock, asynchronous active-low reset
//     hsel, htrans, hwrite, hsize, haddr, hwdata, hready   AHB-Lite inputs
//     hreadyout, hresp, hrdata                             AHB-Lite outputs
//     c_rd_en             read request, held until the cache drops c_busy
//     c_wr_en             write request, single-cycle pulse
//     c_addr              cache address (word or byte form, see WORD_ADDR)
//     c_wdata, c_mask     write data on AHB byte lanes, byte enables
//     c_rdata, c_busy     cache read data and busy flag
module ahbl_cache_bridge
  import ahbl_cache_bridge_pkg::*;
#(
  parameter int unsigned W_ADDR    = 32,
  parameter bit          WORD_ADDR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_x,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [W_ADDR-1:0] haddr,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic              c_rd_en,
  output logic              c_wr_en,
  output logic [31:0]       c_addr,
  output logic [31:0]       c_wdata,
  output logic [3:0]        c_mask,
  input  logic [31:0]       c_rdata,
  input  logic              c_busy
);

  state_t      r_state;
  state_t      w_next;
  state_t      w_issue;
  logic [31:0] w_haddr32;
  logic [31:0] w_caddr;
  logic [3:0]  w_mask;
  logic        w_misaligned;
  logic        w_accept;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_hrdata;
  logic [3:0]  r_mask;

  assign w_haddr32 = 32'(haddr);
  assign w_caddr   = WORD_ADDR ? {2'b00, w_haddr32[31:2]} : {w_haddr32[31:2], 2'b00};

  // ERR2 already shows hreadyout=1, so an address phase there is a real one.
  assign w_accept = ((r_state == IDLE) || (r_state == ERR2)) && hsel && hready &&
                    ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  ahbl_strb_gen u_strb (
    .hsize      (hsize),
    .addr       (w_haddr32[1:0]),
    .mask       (w_mask),
    .misaligned (w_misaligned)
  );

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_addr   <= '0;
      r_mask   <= '0;
      r_wdata  <= '0;
      r_hrdata <= '0;
    end else begin
      if (w_accept && !w_misaligned) begin
        r_addr <= w_caddr;
        r_mask <= hwrite ? w_mask : '1;
      end
      if (r_state == WR_ISSUE)           r_wdata  <= hwdata;
      if (r_state == RD_WAIT && !c_busy) r_hrdata <= c_rdata;
    end
  end

  always_comb begin
    w_issue = IDLE;
    if (w_accept) w_issue = w_misaligned ? ERR1 : (hwrite ? WR_ISSUE : RD_ISSUE);
  end

  always_comb begin
    w_next    = r_state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    c_rd_en   = 1'b0;
    c_wr_en   = 1'b0;
    case (r_state)
      IDLE:     w_next = w_issue;
      RD_ISSUE: begin
        c_rd_en   = 1'b1;
        hreadyout = 1'b0;
        w_next    = RD_WAIT;
      end
      RD_WAIT: begin
        c_rd_en   = 1'b1;
        hreadyout = 1'b0;
        if (!c_busy) w_next = IDLE;
      end
      WR_ISSUE: begin
        c_wr_en   = 1'b1;
        hreadyout = 1'b0;
        w_next    = WR_WAIT_HI;
      end
      WR_WAIT_HI: begin
        hreadyout = 1'b0;
        if (c_busy) w_next = WR_WAIT_LO;
      end
      WR_WAIT_LO: begin
        hreadyout = 1'b0;
        if (!c_busy) w_next = IDLE;
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        w_next    = ERR2;
      end
      ERR2: begin
        hresp  = 1'b1;
        w_next = w_issue;
      end
      default: w_next = IDLE;
    endcase
  end

  // hwdata is only valid in the data phase, which is the WR_ISSUE cycle
  // itself, so the pulse cycle forwards it directly; the register then holds it.
  assign c_wdata = (r_state == WR_ISSUE) ? hwdata : r_wdata;
  assign c_addr  = r_addr;
  assign c_mask  = r_mask;
  assign hrdata  = r_hrdata;

endmodule

// File: tb/tb_ahbl_cache_bridge.sv
module tb_ahbl_cache_bridge;

  logic        clk = 1'b0;
  logic        rst_x;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        c_rd_en;
  logic        c_wr_en;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_mask;
  logic [31:0] c_rdata;
  logic        c_busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] m_hrdata = '0;

  // cache model controls
  int unsigned cm_len   = 0;
  logic [31:0] cm_rdata = '0;
  int unsigned cm_cnt;
  bit          cm_seen;

  always #5 clk = ~clk;

  // single-slave system: global HREADY is this slave's HREADYOUT
  assign hready = hreadyout;

  ahbl_cache_bridge #(.W_ADDR(32), .WORD_ADDR(1'b1)) dut (
    .clk(clk), .rst_x(rst_x), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .c_rd_en(c_rd_en), .c_wr_en(c_wr_en), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_mask(c_mask), .c_rdata(c_rdata), .c_busy(c_busy)
  );

  // Behavioural cache: on a new request raise busy for cm_len cycles
  // (0 = hit, never busy). Read data is only correct while busy is low.
  always @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      c_busy  <= 1'b0;
      cm_cnt  <= 0;
      cm_seen <= 1'b0;
    end else begin
      if (!c_rd_en) cm_seen <= 1'b0;
      if (c_busy) begin
        if (cm_cnt > 1) cm_cnt <= cm_cnt - 1;
        else            c_busy <= 1'b0;
      end else if ((c_wr_en || (c_rd_en && !cm_seen)) && cm_len > 0) begin
        c_busy  <= 1'b1;
        cm_cnt  <= cm_len;
        cm_seen <= c_rd_en;
      end else if (c_rd_en) begin
        cm_seen <= 1'b1;
      end
    end
  end
  assign c_rdata = c_busy ? ~cm_rdata : cm_rdata;

  typedef struct {
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned len;
    int unsigned exp_waits;
    logic [3:0]  exp_mask;
    bit          exp_err;
  } vec_t;

  typedef struct {
    bit          done;
    int unsigned waits;
    int unsigned rd_cycles;
    int unsigned rd_rises;
    int unsigned wr_cycles;
    int unsigned hresp_cnt;
    bit          overlap;
    bit          consec;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    logic [3:0]  mask;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_hreadyout"}, 32'(hreadyout), 32'd1);
    chk({tag, "_hresp"},     32'(hresp),     32'd0);
    chk({tag, "_hrdata"},    hrdata,         32'd0);
    chk({tag, "_c_rd_en"},   32'(c_rd_en),   32'd0);
    chk({tag, "_c_wr_en"},   32'(c_wr_en),   32'd0);
    chk({tag, "_c_addr"},    c_addr,         32'd0);
    chk({tag, "_c_wdata"},   c_wdata,        32'd0);
    chk({tag, "_c_mask"},    32'(c_mask),    32'd0);
  endtask

  // Reference: a transfer of 2^size bytes must start on a 2^size boundary;
  // an accepted transfer stalls for the issue cycle, every busy cycle and
  // the completion cycle; an error stalls once.
  function automatic vec_t model(input vec_t v);
    vec_t        e = v;
    int unsigned nbytes = 32'd1 << v.size;
    e.exp_err   = (v.size > 3'd2) || ((v.addr % nbytes) != 0);
    e.exp_waits = e.exp_err ? 1 : 2 + v.len;
    e.exp_mask  = v.wr ? 4'(((32'd1 << nbytes) - 1) << (v.addr % 4)) : 4'hF;
    return e;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.wr    = 1'($urandom);
    v.size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
    v.addr  = $urandom;
    if ($urandom_range(0, 3) != 0 && v.size <= 3'd2) v.addr = v.addr & ~((32'd1 << v.size) - 1);
    v.wdata = $urandom;
    v.rdata = $urandom;
    v.len   = v.wr ? $urandom_range(1, 6) : (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 8));
    v.exp_waits = 0;
    v.exp_mask  = '0;
    v.exp_err   = 1'b0;
    return v;
  endfunction

  // Starts at a point where hreadyout=1 (idle or a completion cycle); returns
  // at the negedge of this transfer's completion cycle.
  task automatic xfer(input vec_t v, output obs_t o);
    bit prev_rd = 1'b0;
    bit prev_wr = 1'b0;
    o = '{default: 0};
    hsel = 1'b1; htrans = 2'b10; hwrite = v.wr; hsize = v.size; haddr = v.addr;
    cm_len = v.len; cm_rdata = v.rdata;
    @(posedge clk); #1;
    hwdata = v.wdata;
    hsel = 1'b0; htrans = 2'($urandom); haddr = $urandom; hwrite = 1'($urandom);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (c_rd_en && !prev_rd) o.rd_rises++;
      prev_rd = c_rd_en;
      if (c_rd_en) begin
        o.rd_cycles++;
        o.addr = c_addr;
        o.mask = c_mask;
      end
      if (c_wr_en) begin
        o.wr_cycles++;
        o.addr  = c_addr;
        o.mask  = c_mask;
        o.wdata = c_wdata;
        if (prev_wr) o.consec = 1'b1;
      end
      prev_wr = c_wr_en;
      if (c_rd_en && c_wr_en) o.overlap = 1'b1;
      if (hresp) o.hresp_cnt++;
      if (hreadyout) begin
        o.done   = 1'b1;
        o.hrdata = hrdata;
        break;
      end
      o.waits++;
      htrans = 2'($urandom); haddr = $urandom;
    end
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic check_xfer(input string tag, input vec_t v, input obs_t o,
                            input int unsigned ew, input logic [3:0] em, input bit ee);
    bit is_rd = !v.wr && !ee;
    bit is_wr = v.wr && !ee;
    chk({tag, "_done"},      32'(o.done),      32'd1);
    chk({tag, "_waits"},     o.waits,          ew);
    chk({tag, "_hresp"},     o.hresp_cnt,      ee ? 32'd2 : 32'd0);
    chk({tag, "_rd_cycles"}, o.rd_cycles,      is_rd ? ew : 32'd0);
    chk({tag, "_rd_rises"},  o.rd_rises,       is_rd ? 32'd1 : 32'd0);
    chk({tag, "_wr_pulses"}, o.wr_cycles,      is_wr ? 32'd1 : 32'd0);
    chk({tag, "_overlap"},   32'(o.overlap),   32'd0);
    chk({tag, "_wr_consec"}, 32'(o.consec),    32'd0);
    if (!ee) begin
      chk({tag, "_c_addr"}, o.addr,       v.addr >> 2);
      chk({tag, "_c_mask"}, 32'(o.mask),  32'(em));
    end
    if (is_wr) chk({tag, "_c_wdata"}, o.wdata, v.wdata);
    if (is_rd) m_hrdata = v.rdata;
    chk({tag, "_hrdata"}, o.hrdata, m_hrdata);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      hsel = 1'($urandom); htrans = 2'($urandom_range(0, 1)); haddr = $urandom;
      hwrite = 1'($urandom); hsize = 3'($urandom_range(0, 3));
      @(negedge clk);
      chk("idle_hreadyout", 32'(hreadyout), 32'd1);
      chk("idle_quiet", {29'd0, c_rd_en, c_wr_en, hresp}, 32'd0);
    end
    hsel = 1'b0; htrans = 2'b00;
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    vec_t v;
    obs_t o;

    //         wr    size  addr          wdata         rdata         len waits mask   err
    tbl[0] = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0,  2,  4'hF, 1'b0};
    tbl[1] = '{1'b0, 3'd2, 32'h0000_0180, 32'h0,        32'h12345678, 10, 12, 4'hF, 1'b0};
    tbl[2] = '{1'b1, 3'd0, 32'h0000_0203, 32'hAB000000, 32'h0,        3,  5,  4'h8, 1'b0};
    tbl[3] = '{1'b1, 3'd1, 32'h0000_0202, 32'h5A5A0000, 32'h0,        1,  3,  4'hC, 1'b0};
    tbl[4] = '{1'b1, 3'd2, 32'h0000_0204, 32'h01234567, 32'h0,        2,  4,  4'hF, 1'b0};
    tbl[5] = '{1'b0, 3'd2, 32'h0000_0102, 32'h0,        32'h0,        0,  1,  4'h0, 1'b1};
    tbl[6] = '{1'b1, 3'd1, 32'h0000_0101, 32'h0,        32'h0,        1,  1,  4'h0, 1'b1};
    tbl[7] = '{1'b0, 3'd3, 32'h0000_0000, 32'h0,        32'h0,        0,  1,  4'h0, 1'b1};
    tbl[8] = '{1'b0, 3'd0, 32'h0000_0003, 32'h0,        32'hA5A5C3C3, 0,  2,  4'hF, 1'b0};
    tbl[9] = '{1'b1, 3'd1, 32'h0000_0200, 32'h0000BEEF, 32'h0,        1,  3,  4'h3, 1'b0};

    rst_x = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
    haddr = '0; hwdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst_x = 1'b1;
    idle(2);

    for (int i = 0; i < 10; i++) begin
      xfer(tbl[i], o);
      check_xfer($sformatf("tbl%0d", i), tbl[i], o, tbl[i].exp_waits, tbl[i].exp_mask, tbl[i].exp_err);
      if (i % 2 == 1) idle(1);
    end

    // back-to-back write then read to the same address, reset during RD_WAIT
    v = '{1'b1, 3'd2, 32'h0000_0300, 32'hCAFEF00D, 32'h0, 1, 0, 4'h0, 1'b0};
    v = model(v);
    xfer(v, o);
    check_xfer("b2b_wr", v, o, v.exp_waits, v.exp_mask, v.exp_err);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h0000_0300;
    cm_len = 5; cm_rdata = 32'h11111111;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    chk("b2b_rd_issue", 32'(c_rd_en), 32'd1);
    chk("b2b_rd_stall", 32'(hreadyout), 32'd0);
    @(posedge clk); #2;
    chk("b2b_rd_wait_busy", 32'(c_busy), 32'd1);
    chk("b2b_rd_wait_en", 32'(c_rd_en), 32'd1);
    rst_x = 1'b0;
    #1;
    check_reset("midrst");
    m_hrdata = '0;
    @(negedge clk);
    rst_x = 1'b1;
    idle(1);
    v = '{1'b0, 3'd2, 32'h0000_0300, 32'h0, 32'h22222222, 0, 0, 4'h0, 1'b0};
    v = model(v);
    xfer(v, o);
    check_xfer("post_rst_rd", v, o, v.exp_waits, v.exp_mask, v.exp_err);

    // randomized transfers against the reference model
    for (int i = 0; i < 60; i++) begin
      v = model(rand_vec());
      xfer(v, o);
      check_xfer($sformatf("rnd%0d", i), v, o, v.exp_waits, v.exp_mask, v.exp_err);
      idle($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahbl_cache_bridge.md
Name: ahbl_cache_bridge

Overview:
- AHB-Lite slave that converts Hazard3 bus transfers into the single-word request/busy protocol of the write-back cache controller directly downstream.
- Latches each address phase and issues one cache request per transfer: a held read request, or a one-cycle write pulse with byte mask.
- Stalls the bus with HREADYOUT until the cache completes the request.
- Rejects misaligned transfers with a two-cycle AHB ERROR response.

Parameters:
- W_ADDR, 32, AHB address width.
- WORD_ADDR, 1, 1 = drive c_addr as word address {2'b00, haddr[31:2]}; 0 = byte address with bits [1:0] forced to 0.

Ports:
- clk  in  1  system clock
- rst_x  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- htrans  in  2  AHB transfer type; only NONSEQ/SEQ are acted on
- hwrite  in  1  write transfer
- hsize  in  3  0 = byte, 1 = half, 2 = word
- haddr  in  W_ADDR  byte address
- hwdata  in  32  write data, data phase
- hready  in  1  global HREADY
- hreadyout  out  1  slave ready
- hresp  out  1  1 = ERROR
- hrdata  out  32  read data
- c_rd_en  out  1  cache read request, held until completion
- c_wr_en  out  1  cache write request, one-cycle pulse
- c_addr  out  32  cache address
- c_wdata  out  32  write data, byte lanes as on hwdata
- c_mask  out  4  byte enables
- c_rdata  in  32  cache read data, valid while c_rd_en is high and c_busy is low
- c_busy  in  1  cache busy

Behaviour:
- Reset values: state = IDLE; hreadyout = 1; hresp = 0; hrdata = 0; c_rd_en = 0; c_wr_en = 0; c_addr = 0; c_wdata = 0; c_mask = 0.
- Address phase accept: when hsel & htrans[1] & hready, latch addr, write, size and mask.
  - Aligned transfer goes to RD_ISSUE or WR_ISSUE.
  - Misaligned transfer (half with addr[0]=1, word with addr[1:0]≠0, or hsize>2) goes to ERR1.
  - IDLE/BUSY htrans: zero-wait OKAY, no cache access.
- Mask generation: byte → 1<<addr[1:0]; half → 4'b0011<<addr[1:0]; word → 4'b1111.
- RD_ISSUE:
  - Drive c_rd_en = 1, c_addr, c_mask = 4'b1111; hreadyout = 0.
  - Next state RD_WAIT.
- RD_WAIT:
  - Keep c_rd_en = 1.
  - When c_busy = 0: register hrdata <= c_rdata, drop c_rd_en, hreadyout = 1 next cycle, return to IDLE/accept.
  - Hit latency: 2 wait states. Miss: completes on the first c_busy = 0 after c_busy rose.
- WR_ISSUE (first data-phase cycle):
  - c_wr_en = 1 for exactly one cycle; c_wdata <= hwdata, c_mask <= latched mask.
  - Next state WR_WAIT_HI.
- WR_WAIT_HI: wait for c_busy = 1. Next state WR_WAIT_LO.
- WR_WAIT_LO: on c_busy = 0, complete with hreadyout = 1 and return to IDLE.
- c_wr_en must never be high in two consecutive cycles. c_rd_en and c_wr_en are never high together.
- ERR1: hreadyout = 0, hresp = 1. Next state ERR2.
- ERR2: hreadyout = 1, hresp = 1. Next state IDLE. The cache is never touched.
- Back-to-back transfers: a new address phase is sampled in the same cycle hreadyout returns 1. No idle bubble is required beyond the issue cycle.
- hrdata holds its last value between reads.
- Reset mid-operation: all state and outputs return to reset values immediately. The pending transfer is abandoned and no retry is made.
- An address phase with hsel = 0 during a stall has no effect.

Decomposition:
- Shared header for the codebase: state encodings (IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT_HI, WR_WAIT_LO, ERR1, ERR2), HTRANS/HSIZE localparams.
- One combinational sub-module, ahbl_strb_gen: inputs hsize and addr[1:0]; outputs mask[3:0] and misaligned.

Test Plan:
- Read hit at 0x100, cache model returns 0xDEADBEEF with c_busy never high → hrdata = 0xDEADBEEF after 2 wait states; c_addr = 0x40; c_rd_en high for exactly 2 cycles.
- Read miss, c_busy high for 10 cycles → hready stalled; hrdata captured from c_rdata on the c_busy fall cycle; no second c_rd_en rising edge.
- Byte write 0xAB at 0x203, hwdata = 0xAB000000 → single c_wr_en pulse; c_mask = 4'b1000; c_wdata = 0xAB000000; completes after c_busy high→low.
- Half write at 0x202 → c_mask = 4'b1100. Word write at 0x204 → c_mask = 4'b1111.
- Word read at 0x102 → ERR1/ERR2 sequence: hresp = 1 for 2 cycles, hreadyout 0 then 1; c_rd_en and c_wr_en stay 0.
- Back-to-back write then read to the same address with rst_x pulsed low during the read's RD_WAIT → outputs return to reset values immediately; after release, a fresh read issues normally.
